// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV subset R-type / LD / SD / BEQ.
// Outputs are decoded from state; only FETCH's IR/PC writes also depend on memReady.
module multicycle_control_unit #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [31:0]            instruction,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   pcWriteCond,
  output logic                   pcSource,
  output logic                   iOrD,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   irWrite,
  output logic                   regWrite,
  output logic                   memToReg,
  output logic                   aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             aluOp,
  output logic [1:0]             immSel,
  output logic [3:0]             stateOut,
  output logic [COUNT_WIDTH-1:0] retiredCount,
  output logic                   illegal
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    LOAD_WB   = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_R  = 7'b0110011;

  state_e                 state_q, state_d;
  logic [1:0]             imm_sel_q, imm_sel_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   illegal_q, illegal_d;
  logic                   retire;
  logic [6:0]             opcode;
  logic [2:0]             funct3;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      imm_sel_q <= 2'b11;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      imm_sel_q <= imm_sel_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    imm_sel_d   = imm_sel_q;
    retired_d   = retired_q;
    illegal_d   = illegal_q;
    retire      = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 1'b0;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regWrite    = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        aluSrcB = 2'b11;
        if (opcode == OP_LD) begin
          imm_sel_d = 2'b00;
          state_d   = MEM_ADDR;
        end else if (opcode == OP_SD) begin
          imm_sel_d = 2'b01;
          state_d   = MEM_ADDR;
        end else if (opcode == OP_BR && funct3 == 3'b000) begin
          imm_sel_d = 2'b10;
          state_d   = BRANCH;
        end else if (opcode == OP_R) begin
          imm_sel_d = 2'b11;
          state_d   = EXEC_R;
        end else begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_LD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (memReady) state_d = LOAD_WB;
      end
      LOAD_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        retire   = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        retire   = memReady;
      end
      EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = R_WB;
      end
      R_WB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 1'b1;
        retire      = 1'b1;
      end
      TRAP: state_d = TRAP;
      default: state_d = IDLE;
    endcase
    // Every completing state shares the instruction-boundary run check.
    if (retire) begin
      retired_d = retired_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      state_d   = run ? FETCH : IDLE;
    end
  end

  assign immSel       = imm_sel_q;
  assign stateOut     = state_q;
  assign retiredCount = retired_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: builds each instruction's expected state trace from its class
// and memory wait counts, then checks every cycle's outputs against that trace.
module tb_multicycle_control_unit;

  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [31:0]   instruction = '0;
  logic          memReady = 1'b0;
  logic          pcWrite, pcWriteCond, pcSource, iOrD, memRead, memWrite;
  logic          irWrite, regWrite, memToReg, aluSrcA;
  logic [1:0]    aluSrcB, aluOp, immSel;
  logic [3:0]    stateOut;
  logic [CW-1:0] retiredCount;
  logic          illegal;
  logic [13:0]   ctrl_vec;

  int n_cmp = 0;
  int n_err = 0;
  int exp_imm;
  int exp_cnt;
  bit exp_ill;

  always #5 clock = ~clock;

  multicycle_control_unit #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .instruction(instruction),
    .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .pcSource(pcSource), .iOrD(iOrD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regWrite(regWrite), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .immSel(immSel),
    .stateOut(stateOut), .retiredCount(retiredCount), .illegal(illegal)
  );

  assign ctrl_vec = {pcWrite, pcWriteCond, pcSource, iOrD, memRead, memWrite,
                     irWrite, regWrite, memToReg, aluSrcA, aluSrcB, aluOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control table per state number; bit order matches ctrl_vec.
  function automatic logic [13:0] exp_ctrl(input int st, input logic mr);
    logic [13:0] v;
    v = '0;
    case (st)
      1: v = {mr, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      2: v = {10'b0, 2'b11, 2'b00};
      3: v = {9'b0, 1'b1, 2'b10, 2'b00};
      4: v = {3'b0, 1'b1, 1'b1, 9'b0};
      5: v = {7'b0, 1'b1, 1'b1, 5'b0};
      6: v = {3'b0, 1'b1, 1'b0, 1'b1, 8'b0};
      7: v = {9'b0, 1'b1, 2'b00, 2'b10};
      8: v = {7'b0, 1'b1, 6'b0};
      9: v = {1'b0, 1'b1, 1'b1, 6'b0, 1'b1, 2'b00, 2'b01};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // kind: 0 R-type, 1 LD, 2 SD, 3 BEQ
  function automatic logic [31:0] make_ins(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0000011;
      2: r[6:0] = 7'b0100011;
      default: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
    endcase
    return r;
  endfunction

  function automatic int imm_of(input int kind);
    case (kind)
      0: return 3;
      1: return 0;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  task automatic check_all(input int st, input logic mr);
    check("state", 32'(stateOut), st);
    check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(st, mr)));
    check("immSel", 32'(immSel), exp_imm);
    check("retired", 32'(retiredCount), exp_cnt);
    check("illegal", 32'(illegal), 32'(exp_ill));
  endtask

  // Called just after a rising edge: drive, check this cycle, advance one edge.
  task automatic step(input int st, input logic mr, input logic rn, input logic [31:0] ins);
    memReady    = mr;
    run         = rn;
    instruction = ins;
    #1;
    check_all(st, mr);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    memReady = rb();
    run      = rb();
    @(posedge clock);
    #1;
    exp_imm = 3;
    exp_cnt = 0;
    exp_ill = 1'b0;
    check_all(0, memReady);
    reset = 1'b0;
  endtask

  task automatic idle_go(input int k);
    repeat (k) step(0, rb(), 1'b0, $urandom);
    step(0, rb(), 1'b1, $urandom);
  endtask

  task automatic run_instr(input int kind, input logic [31:0] ins, input logic run_end);
    int wf, wm;
    wf = $urandom_range(0, 2);
    wm = $urandom_range(0, 3);
    repeat (wf) step(1, 1'b0, rb(), $urandom);
    step(1, 1'b1, rb(), $urandom);
    step(2, rb(), rb(), ins);
    exp_imm = imm_of(kind);
    case (kind)
      0: begin
        step(7, rb(), rb(), ins);
        step(8, rb(), run_end, ins);
      end
      1: begin
        step(3, rb(), rb(), ins);
        repeat (wm) step(4, 1'b0, rb(), ins);
        step(4, 1'b1, rb(), ins);
        step(5, rb(), run_end, ins);
      end
      2: begin
        step(3, rb(), rb(), ins);
        repeat (wm) step(6, 1'b0, rb(), ins);
        step(6, 1'b1, run_end, ins);
      end
      default: step(9, rb(), run_end, ins);
    endcase
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (!run_end) idle_go($urandom_range(0, 2));
  endtask

  initial begin
    int kind;
    logic [31:0] ld_ins;
    do_reset();
    idle_go(1);

    run_instr(0, 32'h00B50533, 1'b1);
    run_instr(1, 32'h0002B303, 1'b1);
    run_instr(2, 32'h0062B023, 1'b1);
    run_instr(3, 32'h00628463, 1'b0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      run_instr(kind, make_ins(kind), $urandom_range(0, 3) != 0);
    end

    do_reset();
    idle_go(0);
    for (int i = 0; i < 16; i++)
      run_instr(0, make_ins(0), i != 15);

    // Reset asserted while an LD waits in MEM_READ.
    ld_ins = make_ins(1);
    step(1, 1'b1, rb(), $urandom);
    step(2, rb(), rb(), ld_ins);
    exp_imm = 0;
    step(3, rb(), rb(), ld_ins);
    step(4, 1'b0, rb(), ld_ins);
    step(4, 1'b0, rb(), ld_ins);
    do_reset();

    // Unsupported opcode traps and stays trapped.
    idle_go(0);
    step(1, 1'b1, rb(), $urandom);
    step(2, rb(), rb(), 32'h0000007F);
    exp_ill = 1'b1;
    for (int k = 0; k < 20; k++)
      step(10, 1'(k), rb(), 32'h0000007F);
    do_reset();
    idle_go(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle control FSM that sequences the RISC-V datapath for the supported subset: R-type, LD, SD, BEQ.
- Drives PC/IR write enables, memory requests, ALU operand/op selects, register-file write-back and the immediate-format select consumed by the immediate generator.
- Handshakes with a variable-latency unified memory through memReady.
- Exposes state, a retired-instruction counter and a sticky illegal-instruction flag for debug and verification.

Parameters:
COUNT_WIDTH, 32, width of retiredCount; wraps modulo 2^COUNT_WIDTH.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  permits a new instruction fetch; sampled only in IDLE and at instruction boundaries
instruction  input  32  IR contents; valid from DECODE onward
memReady  input  1  memory done: read data valid / write accepted this cycle
pcWrite  output  1  unconditional PC write (PC+4 in FETCH)
pcWriteCond  output  1  PC write if ALU zero (BEQ)
pcSource  output  1  0 = ALU result, 1 = ALUOut (branch target)
iOrD  output  1  memory address select: 0 = PC, 1 = ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  latch IR from memory data
regWrite  output  1  register-file write enable
memToReg  output  1  write-back source: 0 = ALUOut, 1 = MDR
aluSrcA  output  1  0 = PC, 1 = register A
aluSrcB  output  2  00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate (branch offset)
aluOp  output  2  00 = add, 01 = subtract/compare, 10 = decode funct3/funct7
immSel  output  2  00 = I, 01 = S, 10 = B, 11 = none
stateOut  output  4  current state encoding
retiredCount  output  COUNT_WIDTH  number of completed instructions
illegal  output  1  sticky; set on unsupported opcode/funct3

Behaviour:
- Reset: state IDLE(0); immSel = 11; retiredCount = 0; illegal = 0; all enables and selects 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, LOAD_WB 5, MEM_WRITE 6, EXEC_R 7, R_WB 8, BRANCH 9, TRAP 10.
- Outputs are combinational from state. The only exception is irWrite/pcWrite in FETCH, which are additionally gated by memReady. Any signal not listed for a state is 0.
- IDLE: no outputs. Go to FETCH when run = 1.
- FETCH: memRead = 1, iOrD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 00.
  - Stay while memReady = 0.
  - When memReady = 1: irWrite = 1, pcWrite = 1, pcSource = 0; go to DECODE.
- DECODE: aluSrcA = 0, aluSrcB = 11, aluOp = 00 (branch target into ALUOut). immSel is registered from instruction[6:0]:
  - 0000011 -> immSel 00; next MEM_ADDR
  - 0100011 -> immSel 01; next MEM_ADDR
  - 1100011 with funct3 = 000 -> immSel 10; next BRANCH
  - 0110011 -> immSel 11; next EXEC_R
  - anything else -> TRAP
  - immSel holds until the next DECODE.
- MEM_ADDR: aluSrcA = 1, aluSrcB = 10, aluOp = 00. Go to MEM_READ if opcode is LD, else MEM_WRITE.
- MEM_READ: memRead = 1, iOrD = 1. Wait for memReady, then go to LOAD_WB.
- LOAD_WB: regWrite = 1, memToReg = 1.
- MEM_WRITE: memWrite = 1, iOrD = 1. Wait for memReady; memWrite stays asserted until then.
- EXEC_R: aluSrcA = 1, aluSrcB = 00, aluOp = 10. Go to R_WB.
- R_WB: regWrite = 1, memToReg = 0.
- BRANCH: aluSrcA = 1, aluSrcB = 00, aluOp = 01, pcWriteCond = 1, pcSource = 1.
- Instruction completion:
  - Completing states: LOAD_WB, MEM_WRITE (on memReady), R_WB, BRANCH.
  - On completion, retiredCount increments by 1 (wrapping from all-ones to 0).
  - Next state is FETCH if run = 1, else IDLE.
- Instruction latencies with zero memory wait:
  - R-type: 4 cycles
  - BEQ: 3 cycles
  - SD: 4 cycles
  - LD: 5 cycles
  - Each memory wait cycle adds 1.
- TRAP: illegal = 1 (sticky). All enables 0. Remains in TRAP until reset; retiredCount is not incremented.
- run deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- memReady outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Reset asserted in any state, including during a memory wait: next edge restores all reset values. No write enable is asserted in the reset cycle's outputs after the edge.

Test Plan:
- Reset, run = 1, memReady = 1, R-type 0x00B50533 -> stateOut 0,1,2,7,8,1; regWrite = 1 only in state 8; retiredCount = 1.
- LD 0x0002B303 with memReady low 2 extra cycles in MEM_READ -> stateOut 1,2,3,4,4,4,5; immSel = 00; memRead & iOrD high throughout state 4; total 7 cycles.
- SD 0x0062B023, then BEQ 0x00628463 -> immSel 01 then 10; memWrite only in state 6; pcWriteCond & pcSource high only in state 9; retiredCount = 2.
- Opcode 0x0000007F -> TRAP(10); illegal = 1 persists 20 cycles with memReady toggling; all enables 0; retiredCount unchanged.
- run dropped during MEM_ADDR of an LD -> LD completes, next state IDLE; FSM resumes at FETCH only after run = 1 again.
- retiredCount with COUNT_WIDTH = 4 after 16 R-types -> wraps to 0. Reset asserted in MEM_READ -> stateOut 0, immSel 11, counter 0, illegal 0 after one edge.
